iodelay_tap_ctrl: RTL and testbench
===================================

Name: iodelay_tap_ctrl

Overview:
- Controller that sequences the IDELAYCTRL reset/ready handshake and programs the per-lane IDELAYE2 taps of the RGMII RX input path.
- It runs in VAR_LOAD mode: a shared 5-bit CNTVALUEIN bus plus a per-lane LD strobe. Each load is checked against the lane's CNTVALUEOUT readback.
- Sits beside the RX delay primitives. It accepts tap-update requests from a CSR/calibration master over a valid/ready interface.
- Re-runs the bring-up sequence automatically whenever IDELAYCTRL drops RDY.

Parameters:
- num_lanes_p, 5, number of IDELAYE2 lanes (rxd[3:0] + rx_ctl).
- hold_cycles_p, 16, cycles IDELAYCTRL RST is held high (must be >=12 at 200 MHz for the 60 ns minimum).
- rdy_timeout_p, 1024, cycles to wait for RDY before declaring timeout and retrying.
- init_tap_p, 0, tap value loaded into every lane after each bring-up.
- lane_width_lp, max(1,$clog2(num_lanes_p)), local parameter: lane index width.

Ports:
- clk_i  in  1  200 MHz IDELAY reference clock; also drives the IDELAYE2 C pins.
- reset_n_i  in  1  asynchronous, active-low reset.
- idelayctrl_rdy_i  in  1  IDELAYCTRL RDY.
- idelayctrl_rst_o  out  1  IDELAYCTRL RST, active-high.
- cntvalue_o  out  5  shared CNTVALUEIN bus to all lanes.
- ld_o  out  num_lanes_p  per-lane LD strobe.
- cntvalueout_i  in  5*num_lanes_p  per-lane CNTVALUEOUT; lane n occupies bits [5n+4:5n].
- cfg_v_i  in  1  tap-update request valid.
- cfg_all_i  in  1  broadcast: load cfg_tap_i into every lane.
- cfg_lane_i  in  lane_width_lp  target lane when cfg_all_i=0.
- cfg_tap_i  in  5  tap value.
- cfg_ready_o  out  1  request accepted when cfg_v_i & cfg_ready_o.
- ctrl_ready_o  out  1  delays calibrated; RX path usable.
- verify_err_o  out  num_lanes_p  sticky, per lane: readback mismatch.
- cfg_err_o  out  1  sticky: out-of-range lane requested.
- timeout_o  out  1  sticky: RDY timeout occurred at least once.
- err_clr_i  in  1  clears all sticky error bits; takes priority over a same-cycle set.

Behaviour:
- Single clock domain: clk_i. Reset is asynchronous, active-low (reset_n_i).
- Values while reset_n_i=0:
  - idelayctrl_rst_o=1.
  - ld_o=0, cntvalue_o=0.
  - cfg_ready_o=0, ctrl_ready_o=0.
  - all error bits 0.
  - shadow taps = init_tap_p.
  - state=HOLD, counter=0.
- All outputs are registered.
- HOLD: idelayctrl_rst_o=1 for exactly hold_cycles_p cycles after reset release, then go to WAIT_RDY with rst=0.
- WAIT_RDY:
  - Counter counts cycles spent in this state.
  - If idelayctrl_rdy_i=1, go to INIT with lane index 0.
  - If the counter reaches rdy_timeout_p-1 without RDY, set timeout_o and return to HOLD (counter cleared).
- INIT: for each lane n = 0..num_lanes_p-1, run LOAD(n, shadow[n]) then VERIFY(n). After the last lane, go to IDLE. Total 2*num_lanes_p cycles.
- LOAD, 1 cycle: cntvalue_o = tap; ld_o = one-hot(lane), or all ones for a broadcast.
- VERIFY, 1 cycle (the cycle after LD):
  - ld_o=0.
  - Compare cntvalueout_i of each loaded lane with the tap; on mismatch, set that lane's verify_err_o bit.
  - Next state: IDLE, or the next INIT lane.
- IDLE:
  - ctrl_ready_o=1, cfg_ready_o=1 (both combinational with state, registered form).
  - On accept: update the shadow tap(s), then LOAD/VERIFY. cfg_ready_o=0 for those 2 cycles.
  - Out-of-range cfg_lane_i with cfg_all_i=0: set cfg_err_o, no LD, no shadow change, stay in IDLE. It is still a 1-cycle accept.
- RDY drop:
  - In IDLE, LOAD, VERIFY or INIT, idelayctrl_rdy_i=0 sends the block to HOLD next cycle.
  - ctrl_ready_o and cfg_ready_o drop that same cycle.
  - Any load in flight is abandoned. Its shadow update (already committed) is re-applied in INIT.
- Asserting reset_n_i mid-operation returns all state to reset values immediately.
- Minimum accept-to-accept spacing in IDLE is 3 cycles (accept, LOAD, VERIFY).

Decomposition:
- Package iodelay_pkg holds:
  - state enum {HOLD, WAIT_RDY, INIT, IDLE, LOAD, VERIFY}.
  - tap_width_gp=5.
  - the default hold/timeout constants.
- Sub-module iodelay_tap_shadow: per-lane tap register file with single-lane write, broadcast write and reset to init_tap_p.
- The FSM and counters live in the top.

Test Plan:
1. Bring-up:
   - Stimulus: release reset, rdy rises 5 cycles after rst falls, hold_cycles_p=16, cntvalueout_i tracks LD.
   - Required: rst high exactly 16 cycles; 5 LD pulses at 2-cycle spacing, each with cntvalue_o=0; ctrl_ready_o=1 on cycle 10 after rdy is seen; no errors.
2. Single update:
   - Stimulus: in IDLE, cfg lane=2, tap=13.
   - Required: next cycle ld_o=5'b00100 with cntvalue_o=13; cfg_ready_o low for 2 cycles; verify_err_o=0.
3. Broadcast with bad readback:
   - Stimulus: cfg_all_i=1, tap=31; the lane 4 model returns 30.
   - Required: ld_o=5'b11111 for one cycle; verify_err_o=5'b10000; err_clr_i clears it.
4. Timeout:
   - Stimulus: rdy held 0, rdy_timeout_p=8.
   - Required: timeout_o sets after 8 WAIT_RDY cycles; rst re-asserts for 16 cycles; the sequence repeats.
5. RDY drop:
   - Stimulus: after lane 1 is set to 7, drop rdy for 1 cycle in IDLE.
   - Required: ctrl_ready_o=0, full re-bring-up, INIT reloads lane 1 with 7 and the other lanes with init_tap_p.
6. Bad lane:
   - Stimulus: cfg lane=6, cfg_all_i=0.
   - Required: accepted in 1 cycle, cfg_err_o=1, ld_o stays 0.

Source files
------------

// File: rtl/iodelay_pkg.sv
// iodelay_pkg
// Shared definitions for the RGMII RX IDELAYE2 tap controller: the controller
// state encoding, the CNTVALUE bus width and the default bring-up timing.
// No ports (package).
package iodelay_pkg;

    typedef enum logic [2:0] {
        HOLD,
        WAIT_RDY,
        INIT,
        IDLE,
        LOAD,
        VERIFY
    } state_e;

    localparam int tap_width_gp   = 5;
    // 16 cycles at 200 MHz = 80 ns, above the 60 ns IDELAYCTRL RST minimum.
    localparam int hold_cycles_gp = 16;
    localparam int rdy_timeout_gp = 1024;

endpackage

// File: rtl/iodelay_tap_shadow.sv
// iodelay_tap_shadow
// Per-lane shadow copy of the programmed IDELAYE2 tap values. The shadow is
// what INIT replays after every bring-up, so committed updates survive an
// IDELAYCTRL RDY drop.
// Ports:
//   clk_i, reset_n_i  clock, asynchronous active-low reset (taps -> init_tap_p)
//   wr_v_i            write strobe
//   wr_all_i          write wr_tap_i into every lane
//   wr_lane_i         target lane when wr_all_i=0 (out-of-range lanes ignored)
//   wr_tap_i          tap value to store
//   taps_o            all shadow taps, lane n at [5n+4:5n]
module iodelay_tap_shadow
    import iodelay_pkg::*;
#(
    parameter int  num_lanes_p   = 5,
    parameter int  init_tap_p    = 0,
    localparam int lane_width_lp = (num_lanes_p > 1) ? $clog2(num_lanes_p) : 1
) (
    input  logic                                  clk_i,
    input  logic                                  reset_n_i,
    input  logic                                  wr_v_i,
    input  logic                                  wr_all_i,
    input  logic [lane_width_lp-1:0]              wr_lane_i,
    input  logic [tap_width_gp-1:0]               wr_tap_i,
    output logic [num_lanes_p*tap_width_gp-1:0]   taps_o
);

    logic [tap_width_gp-1:0] tap_q [num_lanes_p];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int n = 0; n < num_lanes_p; n++) begin
                tap_q[n] <= tap_width_gp'(init_tap_p);
            end
        end else if (wr_v_i) begin
            for (int n = 0; n < num_lanes_p; n++) begin
                if (wr_all_i || (int'(wr_lane_i) == n)) begin
                    tap_q[n] <= wr_tap_i;
                end
            end
        end
    end

    for (genvar g = 0; g < num_lanes_p; g++) begin : g_taps
        assign taps_o[g*tap_width_gp +: tap_width_gp] = tap_q[g];
    end

endmodule

// File: rtl/iodelay_tap_ctrl.sv
// iodelay_tap_ctrl
// Sequences the IDELAYCTRL RST/RDY handshake and programs the RGMII RX
// IDELAYE2 lanes in VAR_LOAD mode (shared CNTVALUEIN, per-lane LD), checking
// each load against the lane's CNTVALUEOUT readback one cycle later.
// Ports:
//   clk_i             200 MHz IDELAY reference clock
//   reset_n_i         asynchronous active-low reset
//   idelayctrl_rdy_i  IDELAYCTRL RDY; a drop outside HOLD/WAIT_RDY restarts bring-up
//   idelayctrl_rst_o  IDELAYCTRL RST (active-high)
//   cntvalue_o        shared CNTVALUEIN bus
//   ld_o              per-lane LD strobe
//   cntvalueout_i     per-lane CNTVALUEOUT, lane n at [5n+4:5n]
//   cfg_v_i/cfg_ready_o  tap-update request handshake
//   cfg_all_i, cfg_lane_i, cfg_tap_i  broadcast flag, target lane, tap value
//   ctrl_ready_o      delays calibrated, RX path usable
//   verify_err_o      sticky per-lane readback mismatch
//   cfg_err_o         sticky out-of-range lane request
//   timeout_o         sticky RDY timeout
//   err_clr_i         clears all sticky errors, wins over a same-cycle set
module iodelay_tap_ctrl
    import iodelay_pkg::*;
#(
    parameter int  num_lanes_p   = 5,
    parameter int  hold_cycles_p = hold_cycles_gp,
    parameter int  rdy_timeout_p = rdy_timeout_gp,
    parameter int  init_tap_p    = 0,
    localparam int lane_width_lp = (num_lanes_p > 1) ? $clog2(num_lanes_p) : 1
) (
    input  logic                                clk_i,
    input  logic                                reset_n_i,
    input  logic                                idelayctrl_rdy_i,
    output logic                                idelayctrl_rst_o,
    output logic [tap_width_gp-1:0]             cntvalue_o,
    output logic [num_lanes_p-1:0]              ld_o,
    input  logic [num_lanes_p*tap_width_gp-1:0] cntvalueout_i,
    input  logic                                cfg_v_i,
    input  logic                                cfg_all_i,
    input  logic [lane_width_lp-1:0]            cfg_lane_i,
    input  logic [tap_width_gp-1:0]             cfg_tap_i,
    output logic                                cfg_ready_o,
    output logic                                ctrl_ready_o,
    output logic [num_lanes_p-1:0]              verify_err_o,
    output logic                                cfg_err_o,
    output logic                                timeout_o,
    input  logic                                err_clr_i
);

    localparam int cnt_max_lp = (hold_cycles_p > rdy_timeout_p) ? hold_cycles_p : rdy_timeout_p;
    localparam int cnt_w_lp   = (cnt_max_lp > 2) ? $clog2(cnt_max_lp) : 1;
    localparam logic [cnt_w_lp-1:0]      hold_last_lp = cnt_w_lp'(hold_cycles_p - 1);
    localparam logic [cnt_w_lp-1:0]      to_last_lp   = cnt_w_lp'(rdy_timeout_p - 1);
    localparam logic [lane_width_lp-1:0] lane_last_lp = lane_width_lp'(num_lanes_p - 1);

    state_e                          state_q, state_d;
    logic [cnt_w_lp-1:0]             cnt_q, cnt_d;
    logic [lane_width_lp-1:0]        lane_q, lane_d, lane_nx;
    logic                            init_q, init_d;
    logic                            rst_q, rst_d;
    logic [num_lanes_p-1:0]          ld_q, ld_d;
    logic [num_lanes_p-1:0]          mask_q, mask_d;
    logic [tap_width_gp-1:0]         tap_q, tap_d;
    logic                            cfg_ready_q, cfg_ready_d;
    logic                            ctrl_ready_q, ctrl_ready_d;
    logic [num_lanes_p-1:0]          verify_err_q, verify_set;
    logic                            cfg_err_q, cfg_err_set;
    logic                            timeout_q, timeout_set;
    logic                            accept, lane_ok, shadow_we;
    logic [num_lanes_p*tap_width_gp-1:0] shadow_taps;

    function automatic logic [num_lanes_p-1:0] onehot(input logic [lane_width_lp-1:0] l);
        return num_lanes_p'(1) << l;
    endfunction

    iodelay_tap_shadow #(
        .num_lanes_p (num_lanes_p),
        .init_tap_p  (init_tap_p)
    ) u_shadow (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .wr_v_i    (shadow_we),
        .wr_all_i  (cfg_all_i),
        .wr_lane_i (cfg_lane_i),
        .wr_tap_i  (cfg_tap_i),
        .taps_o    (shadow_taps)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = '0;
        lane_d       = lane_q;
        init_d       = init_q;
        rst_d        = 1'b0;
        ld_d         = '0;
        mask_d       = mask_q;
        tap_d        = tap_q;
        cfg_ready_d  = 1'b0;
        ctrl_ready_d = 1'b0;
        verify_set   = '0;
        cfg_err_set  = 1'b0;
        timeout_set  = 1'b0;
        shadow_we    = 1'b0;
        accept       = 1'b0;
        lane_ok      = cfg_all_i || (int'(cfg_lane_i) < num_lanes_p);
        lane_nx      = lane_q + 1'b1;

        unique case (state_q)
            HOLD: begin
                if (cnt_q == hold_last_lp) begin
                    state_d = WAIT_RDY;
                end else begin
                    rst_d = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_RDY: begin
                if (idelayctrl_rdy_i) begin
                    state_d = INIT;
                    lane_d  = '0;
                    init_d  = 1'b1;
                    ld_d    = onehot('0);
                    mask_d  = ld_d;
                    tap_d   = shadow_taps[tap_width_gp-1:0];
                end else if (cnt_q == to_last_lp) begin
                    timeout_set = 1'b1;
                    state_d     = HOLD;
                    rst_d       = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            INIT, LOAD: begin
                // ld_o is already registered for this cycle; VERIFY follows.
                if (!idelayctrl_rdy_i) begin
                    state_d = HOLD;
                    rst_d   = 1'b1;
                    init_d  = 1'b0;
                end else begin
                    state_d = VERIFY;
                end
            end
            VERIFY: begin
                if (!idelayctrl_rdy_i) begin
                    state_d = HOLD;
                    rst_d   = 1'b1;
                    init_d  = 1'b0;
                end else begin
                    for (int n = 0; n < num_lanes_p; n++) begin
                        if (mask_q[n] && (cntvalueout_i[n*tap_width_gp +: tap_width_gp] != tap_q)) begin
                            verify_set[n] = 1'b1;
                        end
                    end
                    if (init_q && (lane_q != lane_last_lp)) begin
                        state_d = INIT;
                        lane_d  = lane_nx;
                        ld_d    = onehot(lane_nx);
                        mask_d  = ld_d;
                        tap_d   = shadow_taps[int'(lane_nx)*tap_width_gp +: tap_width_gp];
                    end else begin
                        state_d      = IDLE;
                        init_d       = 1'b0;
                        cfg_ready_d  = 1'b1;
                        ctrl_ready_d = 1'b1;
                    end
                end
            end
            IDLE: begin
                accept = cfg_v_i && cfg_ready_q;
                // An accepted update commits to the shadow even if RDY is
                // dropping, so the following INIT replays it.
                if (accept) begin
                    if (lane_ok) shadow_we   = 1'b1;
                    else         cfg_err_set = 1'b1;
                end
                if (!idelayctrl_rdy_i) begin
                    state_d = HOLD;
                    rst_d   = 1'b1;
                end else if (accept && lane_ok) begin
                    state_d = LOAD;
                    ld_d    = cfg_all_i ? {num_lanes_p{1'b1}} : onehot(cfg_lane_i);
                    mask_d  = ld_d;
                    tap_d   = cfg_tap_i;
                end else begin
                    cfg_ready_d  = 1'b1;
                    ctrl_ready_d = 1'b1;
                end
            end
            default: begin
                state_d = HOLD;
                rst_d   = 1'b1;
                init_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= HOLD;
            cnt_q        <= '0;
            lane_q       <= '0;
            init_q       <= 1'b0;
            rst_q        <= 1'b1;
            ld_q         <= '0;
            mask_q       <= '0;
            tap_q        <= '0;
            cfg_ready_q  <= 1'b0;
            ctrl_ready_q <= 1'b0;
            verify_err_q <= '0;
            cfg_err_q    <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            lane_q       <= lane_d;
            init_q       <= init_d;
            rst_q        <= rst_d;
            ld_q         <= ld_d;
            mask_q       <= mask_d;
            tap_q        <= tap_d;
            cfg_ready_q  <= cfg_ready_d;
            ctrl_ready_q <= ctrl_ready_d;
            verify_err_q <= err_clr_i ? '0   : (verify_err_q | verify_set);
            cfg_err_q    <= err_clr_i ? 1'b0 : (cfg_err_q | cfg_err_set);
            timeout_q    <= err_clr_i ? 1'b0 : (timeout_q | timeout_set);
        end
    end

    assign idelayctrl_rst_o = rst_q;
    assign cntvalue_o       = tap_q;
    assign ld_o             = ld_q;
    assign cfg_ready_o      = cfg_ready_q;
    assign ctrl_ready_o     = ctrl_ready_q;
    assign verify_err_o     = verify_err_q;
    assign cfg_err_o        = cfg_err_q;
    assign timeout_o        = timeout_q;

endmodule

// File: tb/tb_iodelay_tap_ctrl.sv
`timescale 1ns/1ps
module tb_iodelay_tap_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rdy = 1'b0;
    logic        rst;
    logic [4:0]  cntvalue;
    logic [4:0]  ld;
    logic [24:0] cvo = '0;
    logic        cfg_v = 1'b0;
    logic        cfg_all = 1'b0;
    logic [2:0]  cfg_lane = '0;
    logic [4:0]  cfg_tap = '0;
    logic        cfg_ready, ctrl_ready, cfg_err, timeout;
    logic [4:0]  verify_err;
    logic        err_clr = 1'b0;

    int total = 0;
    int bad = 0;
    int rcnt = 0;
    bit force_low = 1'b0;
    bit bad4 = 1'b0;

    always #5 clk = ~clk;

    iodelay_tap_ctrl #(
        .num_lanes_p   (5),
        .hold_cycles_p (16),
        .rdy_timeout_p (8),
        .init_tap_p    (0)
    ) dut (
        .clk_i            (clk),
        .reset_n_i        (reset_n),
        .idelayctrl_rdy_i (rdy),
        .idelayctrl_rst_o (rst),
        .cntvalue_o       (cntvalue),
        .ld_o             (ld),
        .cntvalueout_i    (cvo),
        .cfg_v_i          (cfg_v),
        .cfg_all_i        (cfg_all),
        .cfg_lane_i       (cfg_lane),
        .cfg_tap_i        (cfg_tap),
        .cfg_ready_o      (cfg_ready),
        .ctrl_ready_o     (ctrl_ready),
        .verify_err_o     (verify_err),
        .cfg_err_o        (cfg_err),
        .timeout_o        (timeout),
        .err_clr_i        (err_clr)
    );

    // Advance one clock, then update the IDELAYCTRL and IDELAYE2 models:
    // RDY rises 5 cycles after RST falls; CNTVALUEOUT follows LD (lane 4 can be
    // made to read back one below the loaded value).
    task automatic tick();
        @(posedge clk);
        #1;
        if (!reset_n || rst) begin
            rdy  = 1'b0;
            rcnt = 0;
        end else begin
            if (rcnt < 5) rcnt++;
            rdy = (rcnt >= 5) && !force_low;
        end
        for (int n = 0; n < 5; n++) begin
            if (ld[n]) cvo[n*5 +: 5] = (n == 4 && bad4) ? cntvalue - 5'd1 : cntvalue;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        total++; if (rst !== 1'b1)        begin bad++; $display("FAIL reset_rst got=%0b exp=1", rst); end
        total++; if (ld !== 5'd0)         begin bad++; $display("FAIL reset_ld got=%0h exp=0", ld); end
        total++; if (cntvalue !== 5'd0)   begin bad++; $display("FAIL reset_cntvalue got=%0d exp=0", cntvalue); end
        total++; if (cfg_ready !== 1'b0)  begin bad++; $display("FAIL reset_cfg_ready got=%0b exp=0", cfg_ready); end
        total++; if (ctrl_ready !== 1'b0) begin bad++; $display("FAIL reset_ctrl_ready got=%0b exp=0", ctrl_ready); end
        total++; if (verify_err !== 5'd0) begin bad++; $display("FAIL reset_verify_err got=%0h exp=0", verify_err); end
        total++; if (cfg_err !== 1'b0)    begin bad++; $display("FAIL reset_cfg_err got=%0b exp=0", cfg_err); end
        total++; if (timeout !== 1'b0)    begin bad++; $display("FAIL reset_timeout got=%0b exp=0", timeout); end
    endtask

    // Bring-up from reset release: RST for 16 cycles, then 5 LD pulses.
    task automatic test_bringup();
        int n;
        int npulse;
        int ctrl_t;
        logic [4:0] exp_ld;
        reset_n = 1'b1;
        n = 0;
        do begin tick(); n++; end while (rst && n < 100);
        total++; if (n != 16) begin bad++; $display("FAIL bringup_rst_len got=%0d exp=16", n); end
        npulse = 0;
        ctrl_t = -1;
        for (int t = 1; t <= 40; t++) begin
            tick();
            if (ld !== 5'd0) begin
                exp_ld = 5'd1 << npulse;
                total++; if (t != 5 + 2*npulse) begin bad++; $display("FAIL bringup_ld_time got=%0d exp=%0d", t, 5 + 2*npulse); end
                total++; if (ld !== exp_ld)     begin bad++; $display("FAIL bringup_ld_lane got=%0h exp=%0h", ld, exp_ld); end
                total++; if (cntvalue !== 5'd0) begin bad++; $display("FAIL bringup_tap got=%0d exp=0", cntvalue); end
                npulse++;
            end
            if (ctrl_ready === 1'b1) begin ctrl_t = t; break; end
        end
        total++; if (npulse != 5)         begin bad++; $display("FAIL bringup_pulses got=%0d exp=5", npulse); end
        total++; if (ctrl_t != 15)        begin bad++; $display("FAIL bringup_ready_time got=%0d exp=15", ctrl_t); end
        total++; if (cfg_ready !== 1'b1)  begin bad++; $display("FAIL bringup_cfg_ready got=%0b exp=1", cfg_ready); end
        total++; if (verify_err !== 5'd0) begin bad++; $display("FAIL bringup_verify_err got=%0h exp=0", verify_err); end
        total++; if (timeout !== 1'b0)    begin bad++; $display("FAIL bringup_timeout got=%0b exp=0", timeout); end
    endtask

    task automatic test_single_update();
        cfg_v = 1'b1; cfg_all = 1'b0; cfg_lane = 3'd2; cfg_tap = 5'd13;
        tick();
        cfg_v = 1'b0;
        total++; if (ld !== 5'b00100)    begin bad++; $display("FAIL single_ld got=%0b exp=00100", ld); end
        total++; if (cntvalue !== 5'd13) begin bad++; $display("FAIL single_tap got=%0d exp=13", cntvalue); end
        total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL single_ready_c1 got=%0b exp=0", cfg_ready); end
        tick();
        total++; if (ld !== 5'd0)        begin bad++; $display("FAIL single_ld_off got=%0b exp=0", ld); end
        total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL single_ready_c2 got=%0b exp=0", cfg_ready); end
        tick();
        total++; if (cfg_ready !== 1'b1)  begin bad++; $display("FAIL single_ready_c3 got=%0b exp=1", cfg_ready); end
        total++; if (verify_err !== 5'd0) begin bad++; $display("FAIL single_verify_err got=%0h exp=0", verify_err); end
    endtask

    task automatic test_broadcast_bad_readback();
        bad4 = 1'b1;
        cfg_v = 1'b1; cfg_all = 1'b1; cfg_lane = 3'd0; cfg_tap = 5'd31;
        tick();
        cfg_v = 1'b0;
        total++; if (ld !== 5'b11111)    begin bad++; $display("FAIL bcast_ld got=%0b exp=11111", ld); end
        total++; if (cntvalue !== 5'd31) begin bad++; $display("FAIL bcast_tap got=%0d exp=31", cntvalue); end
        tick();
        total++; if (ld !== 5'd0)        begin bad++; $display("FAIL bcast_ld_off got=%0b exp=0", ld); end
        tick();
        total++; if (verify_err !== 5'b10000) begin bad++; $display("FAIL bcast_verify_err got=%0b exp=10000", verify_err); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        total++; if (verify_err !== 5'd0) begin bad++; $display("FAIL bcast_err_clr got=%0b exp=0", verify_err); end
        // Clear asserted in the VERIFY cycle must beat the mismatch set.
        cfg_v = 1'b1;
        tick();
        cfg_v = 1'b0;
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        total++; if (verify_err !== 5'd0) begin bad++; $display("FAIL bcast_clr_priority got=%0b exp=0", verify_err); end
        cfg_all = 1'b0;
        bad4 = 1'b0;
    endtask

    task automatic test_bad_lane();
        cfg_v = 1'b1; cfg_all = 1'b0; cfg_lane = 3'd6; cfg_tap = 5'd9;
        tick();
        cfg_v = 1'b0;
        total++; if (cfg_err !== 1'b1)   begin bad++; $display("FAIL badlane_err got=%0b exp=1", cfg_err); end
        total++; if (ld !== 5'd0)        begin bad++; $display("FAIL badlane_ld got=%0b exp=0", ld); end
        total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL badlane_ready got=%0b exp=1", cfg_ready); end
        tick();
        total++; if (ld !== 5'd0)        begin bad++; $display("FAIL badlane_ld2 got=%0b exp=0", ld); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        total++; if (cfg_err !== 1'b0)   begin bad++; $display("FAIL badlane_clr got=%0b exp=0", cfg_err); end
    endtask

    task automatic test_rdy_drop();
        int n;
        int npulse;
        int ctrl_t;
        logic [4:0] exp_tap [5];
        exp_tap = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd0};
        // Asynchronous reset mid-cycle takes effect without a clock edge.
        #3 reset_n = 1'b0;
        #1;
        total++; if (rst !== 1'b1)        begin bad++; $display("FAIL async_reset_rst got=%0b exp=1", rst); end
        total++; if (ctrl_ready !== 1'b0) begin bad++; $display("FAIL async_reset_ready got=%0b exp=0", ctrl_ready); end
        tick();
        tick();
        reset_n = 1'b1;
        n = 0;
        do begin tick(); n++; end while (ctrl_ready !== 1'b1 && n < 200);
        total++; if (ctrl_ready !== 1'b1) begin bad++; $display("FAIL drop_initial_ready got=%0b exp=1", ctrl_ready); end
        cfg_v = 1'b1; cfg_all = 1'b0; cfg_lane = 3'd1; cfg_tap = 5'd7;
        tick();
        cfg_v = 1'b0;
        tick();
        tick();
        force_low = 1'b1;
        rdy = 1'b0;
        tick();
        force_low = 1'b0;
        total++; if (ctrl_ready !== 1'b0) begin bad++; $display("FAIL drop_ctrl_ready got=%0b exp=0", ctrl_ready); end
        total++; if (cfg_ready !== 1'b0)  begin bad++; $display("FAIL drop_cfg_ready got=%0b exp=0", cfg_ready); end
        total++; if (rst !== 1'b1)        begin bad++; $display("FAIL drop_rst got=%0b exp=1", rst); end
        n = 0;
        do begin tick(); n++; end while (rst && n < 100);
        total++; if (n != 16) begin bad++; $display("FAIL drop_rst_len got=%0d exp=16", n); end
        npulse = 0;
        ctrl_t = -1;
        for (int t = 1; t <= 40; t++) begin
            tick();
            if (ld !== 5'd0) begin
                if (npulse < 5) begin
                    total++; if (cntvalue !== exp_tap[npulse]) begin bad++; $display("FAIL drop_init_tap lane=%0d got=%0d exp=%0d", npulse, cntvalue, exp_tap[npulse]); end
                end
                npulse++;
            end
            if (ctrl_ready === 1'b1) begin ctrl_t = t; break; end
        end
        total++; if (npulse != 5)         begin bad++; $display("FAIL drop_pulses got=%0d exp=5", npulse); end
        total++; if (ctrl_t != 15)        begin bad++; $display("FAIL drop_ready_time got=%0d exp=15", ctrl_t); end
        total++; if (verify_err !== 5'd0) begin bad++; $display("FAIL drop_verify_err got=%0h exp=0", verify_err); end
    endtask

    task automatic test_timeout();
        int n;
        force_low = 1'b1;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        n = 0;
        do begin tick(); n++; end while (rst && n < 100);
        n = 0;
        do begin tick(); n++; end while (timeout !== 1'b1 && n < 100);
        total++; if (n != 8)       begin bad++; $display("FAIL timeout_wait got=%0d exp=8", n); end
        total++; if (rst !== 1'b1) begin bad++; $display("FAIL timeout_rst got=%0b exp=1", rst); end
        n = 0;
        do begin tick(); n++; end while (rst && n < 100);
        total++; if (n != 16) begin bad++; $display("FAIL timeout_rst_len got=%0d exp=16", n); end
        n = 0;
        do begin tick(); n++; end while (!rst && n < 100);
        total++; if (n != 8)           begin bad++; $display("FAIL timeout_repeat got=%0d exp=8", n); end
        total++; if (timeout !== 1'b1) begin bad++; $display("FAIL timeout_sticky got=%0b exp=1", timeout); end
        total++; if (ld !== 5'd0)      begin bad++; $display("FAIL timeout_ld got=%0b exp=0", ld); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL timeout_clr got=%0b exp=0", timeout); end
        force_low = 1'b0;
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_single_update();
        test_broadcast_bad_readback();
        test_bad_lane();
        test_rdy_drop();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
